// File: rtl/imem_prog_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream into 32-bit little-endian words; word/word_valid are
// combinational so the caller can register them together with the address.
module imem_byte_packer
    import imem_prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_reg;
    logic [31:0] word_reg;

    // Lane gi takes the incoming byte when the index points at it, so the
    // completed word is visible in the same cycle as its last byte.
    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word[8*gi +: 8] = (byte_valid && idx_reg == 2'(gi))
                                   ? byte_data : word_reg[8*gi +: 8];
        end
    endgenerate

    assign word_valid = byte_valid && (idx_reg == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (clear) begin
            idx_reg  <= '0;
            word_reg <= '0;
        end else if (byte_valid) begin
            idx_reg  <= idx_reg + 2'd1;
            word_reg <= word;
        end
    end

endmodule

// File: rtl/imem_prog_loader.sv
// Boot loader: receives a length-prefixed, XOR-checked byte frame, writes the
// words to instruction memory from address 0 and releases the core on success.
module imem_prog_loader
    import imem_prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              global_reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    state_t            state_reg, state_next;
    logic [15:0]       len_reg;
    logic [ADDR_W:0]   word_cnt_reg;
    logic [7:0]        xor_reg;
    logic              imem_we_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [31:0]       imem_wdata_reg;
    logic              core_reset_reg;
    logic              done_reg;
    logic              error_reg;

    logic              xfer;
    logic              restart;
    logic              byte_valid;
    logic              word_valid;
    logic [31:0]       word;
    logic [16:0]       len_full;
    logic              last_word;

    assign rx_ready   = !global_reset && (state_reg inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHK});
    assign xfer       = rx_valid && rx_ready;
    assign restart    = reload && (state_reg inside {ST_RUN, ST_ERR});
    assign byte_valid = xfer && (state_reg == ST_DATA);
    assign len_full   = {1'b0, rx_data, len_reg[7:0]};
    // Counter is one bit wider than the address so a full-depth image of
    // 2**ADDR_W words never aliases word 0 before the checksum byte.
    assign last_word  = (word_cnt_reg == (len_reg[ADDR_W:0] - (ADDR_W+1)'(1)));

    imem_byte_packer u_packer (
        .clk        (clk),
        .clear      (global_reset || restart),
        .byte_valid (byte_valid),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LEN0: if (xfer) state_next = ST_LEN1;
            ST_LEN1: begin
                if (xfer) begin
                    if (len_full > MAX_WORDS)   state_next = ST_ERR;
                    else if (len_full == 17'd0) state_next = ST_CHK;
                    else                        state_next = ST_DATA;
                end
            end
            ST_DATA: if (word_valid && last_word) state_next = ST_CHK;
            ST_CHK:  if (xfer) state_next = (rx_data == xor_reg) ? ST_RUN : ST_ERR;
            ST_RUN:  if (reload) state_next = ST_LEN0;
            ST_ERR:  if (reload) state_next = ST_LEN0;
            default: state_next = ST_LEN0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_reg      <= ST_LEN0;
            len_reg        <= '0;
            word_cnt_reg   <= '0;
            xor_reg        <= '0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
            core_reset_reg <= 1'b1;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            imem_we_reg <= word_valid;
            if (word_valid) begin
                imem_addr_reg  <= word_cnt_reg[ADDR_W-1:0];
                imem_wdata_reg <= word;
                word_cnt_reg   <= word_cnt_reg + (ADDR_W+1)'(1);
            end
            if (restart) begin
                len_reg      <= '0;
                word_cnt_reg <= '0;
                xor_reg      <= '0;
            end else if (xfer && (state_reg inside {ST_LEN0, ST_LEN1, ST_DATA})) begin
                xor_reg <= xor_reg ^ rx_data;
            end
            if (xfer && state_reg == ST_LEN0) len_reg[7:0]  <= rx_data;
            if (xfer && state_reg == ST_LEN1) len_reg[15:8] <= rx_data;
            core_reset_reg <= (state_next != ST_RUN);
            done_reg       <= (state_next == ST_RUN);
            error_reg      <= (state_next == ST_ERR);
        end
    end

    assign imem_we    = imem_we_reg;
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign core_reset = core_reset_reg;
    assign done       = done_reg;
    assign error      = error_reg;

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Boot-time program loader sitting directly upstream of the pipeline's fetch stage.
- Receives a byte stream over a valid/ready handshake and packs the bytes into 32-bit little-endian instruction words.
- Writes the words into instruction memory starting at word address 0.
- Holds the core in reset until a complete, checksum-verified image has been written; fetch then starts from PC 0 on a valid program.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  input  1  system clock
- global_reset  input  1  synchronous, active-high reset
- rx_valid  input  1  byte available on rx_data
- rx_data  input  8  incoming byte
- rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready
- reload  input  1  one-cycle pulse; restarts loading from RUN or ERR
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  ADDR_W  word address
- imem_wdata  output  32  instruction word
- core_reset  output  1  reset to fetch/pipeline, active high
- done  output  1  image loaded and verified
- error  output  1  length or checksum failure

Behaviour:
- Frame format: LEN_LO, LEN_HI, then N = {LEN_HI,LEN_LO} words of 4 bytes each (LSB first), then CHK.
  - CHK must equal the XOR of every preceding byte in the frame, length bytes included.
- States: LEN0, LEN1, DATA, CHK, RUN, ERR.
- Reset: global_reset sampled high → state LEN0.
  - Outputs forced to imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, done=0, error=0.
  - Word count, byte index and running XOR are cleared.
  - rx_ready=0 while global_reset is high.
- rx_ready = 1 in LEN0/LEN1/DATA/CHK and 0 in RUN/ERR. It is decoded from state.
- LEN0 --xfer--> LEN1. Byte is latched as len[7:0].
- LEN1 --xfer--> next state, with len[15:8] latched:
  - N > 2**ADDR_W → ERR.
  - N = 0 → CHK.
  - otherwise → DATA.
- DATA: a 2-bit byte index places byte k into bits [8k+7:8k].
  - On the 4th byte: imem_we=1 for exactly one cycle, on the cycle after that transfer.
  - imem_addr equals the word index (0..N-1); imem_wdata is the assembled word.
  - Word index then increments. After word N-1 the state moves to CHK.
- CHK --xfer-->:
  - byte == running XOR → RUN; core_reset drops to 0 and done rises to 1 on the following clock edge.
  - mismatch → ERR with error=1; core_reset stays 1.
- RUN: core_reset=0, done=1, no writes. reload → LEN0 on the next edge; core_reset returns to 1 and done to 0 on that same edge.
- ERR: error=1, core_reset=1. reload → LEN0 and clears error.
- reload is ignored in LEN0..CHK.
- Gaps: rx_valid low in any receive state holds all state, with no timeout.
- Address wrap: N = 2**ADDR_W is legal. The final word is written at address 2**ADDR_W-1 and the word counter does not wrap before CHK.
- Reset mid-load: any words already written stay in memory. The loader restarts at LEN0 and core_reset stays 1.
- Simultaneous global_reset and reload: global_reset wins.
- Throughput: one byte per cycle sustained; no back-pressure except in RUN/ERR.

Decomposition:
- Shared package: state enum (LEN0..ERR) and the byte-index constant BYTES_PER_WORD=4.
- One sub-module, imem_byte_packer:
  - shift/place logic plus byte index; emits word_valid/word.
  - cleared by global_reset or reload.
- The FSM, length check, XOR accumulation and output registers stay in imem_prog_loader.

Test Plan:
- Basic load, one word: N=1, bytes 01 00 13 05 A0 00 then CHK = 01^00^13^05^A0^00 = B7.
  - Expect one imem_we with addr 0, wdata 0x00A00513.
  - Then core_reset=0 and done=1.
- Bad checksum: same frame with CHK=B6 → error=1, core_reset=1, done=0. Then a reload pulse → rx_ready=1 in LEN0.
- Oversize length (ADDR_W=8): length 01 01 (N=257) → ERR right after LEN1, no imem_we ever.
- Zero length: bytes 00 00 then CHK 00 → no writes, done=1, core_reset=0.
- Full depth with gaps: N=256 with rx_valid randomly deasserted.
  - Expect 256 writes, addresses 0..255 in order, data matching.
  - Done after a correct CHK; no address wrap to 0 before CHK.
- Reset mid-load: global_reset after word 2 of N=4.
  - Expect all outputs at reset values the next cycle.
  - A fresh full frame then loads correctly from address 0.
